// File: rtl/tx_buffer_pkg.sv
// Shared types and constants for the tx_buffer byte FIFO between the bf core and the avr tx port.
package tx_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DEFAULT_LOGDEPTH = 4;

    // Pop-to-pop distance through IDLE -> PULSE -> HOLD.
    localparam int MIN_SEND_GAP = 3;

    function automatic int depth_of(input int logdepth);
        return 1 << logdepth;
    endfunction

endpackage

// File: rtl/tx_buffer_if.sv
// Producer (a_*) and consumer (b_*) handshake signals of tx_buffer; slave is the buffer side.
interface tx_buffer_if;

    logic [7:0] a_data;
    logic       a_send;
    logic       a_busy;
    logic [7:0] b_data;
    logic       b_send;
    logic       b_busy;

    modport master (
        output a_data, a_send, b_busy,
        input  a_busy, b_data, b_send
    );

    modport slave (
        input  a_data, a_send, b_busy,
        output a_busy, b_data, b_send
    );

endinterface

// File: rtl/tx_buffer_mem.sv
// DEPTH x 8 FIFO storage: synchronous write, asynchronous read (maps to distributed RAM).
module tx_buffer_mem
    import tx_buffer_pkg::*;
#(
    parameter int LOGDEPTH = DEFAULT_LOGDEPTH
) (
    input  logic                clk,
    input  logic                we,
    input  logic [LOGDEPTH-1:0] waddr,
    input  logic [7:0]          wdata,
    input  logic [LOGDEPTH-1:0] raddr,
    output logic [7:0]          rdata
);

    localparam int DEPTH = depth_of(LOGDEPTH);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tx_buffer.sv
// Byte FIFO decoupling bf tx from avr tx; optional high-water mark enabled by TX_BUFFER_PEAK_EN.
module tx_buffer
    import tx_buffer_pkg::*;
#(
    parameter int LOGDEPTH = DEFAULT_LOGDEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    tx_buffer_if.slave        bus,
    output logic [LOGDEPTH:0] level,
    output logic [LOGDEPTH:0] peak
);

    localparam int DEPTH = depth_of(LOGDEPTH);
    localparam int LW    = LOGDEPTH + 1;

    logic [LOGDEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOGDEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOGDEPTH:0]   level_q, level_d;
    logic [7:0]          b_data_q, b_data_d;
    logic                b_send_q, b_send_d;
    state_t              state_q, state_d;
    logic [7:0]          rd_data;
    logic                full;
    logic                push;
    logic                pop;

    tx_buffer_mem #(.LOGDEPTH(LOGDEPTH)) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (bus.a_data),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    // Full/empty come only from the level counter; pop decision uses the pre-push level.
    always_comb begin
        full     = (level_q == LW'(DEPTH));
        push     = bus.a_send && !full && !flush;
        pop      = (state_q == IDLE) && (level_q != '0) && !bus.b_busy && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        b_data_d = b_data_q;
        state_d  = state_q;
        b_send_d = (state_q == PULSE);

        case (state_q)
            IDLE:    if (pop) state_d = PULSE;
            PULSE:   state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + LOGDEPTH'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + LOGDEPTH'(1);
            b_data_d = rd_data;
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // A byte already latched for the consumer survives a flush.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            b_data_q <= '0;
            b_send_q <= 1'b0;
            state_q  <= IDLE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            b_data_q <= b_data_d;
            b_send_q <= b_send_d;
            state_q  <= state_d;
        end
    end

    assign bus.a_busy = full;
    assign bus.b_data = b_data_q;
    assign bus.b_send = b_send_q;
    assign level      = level_q;

`ifdef TX_BUFFER_PEAK_EN
    logic [LOGDEPTH:0] peak_q, peak_d;

    always_comb begin
        peak_d = peak_q;
        if (flush) begin
            peak_d = '0;
        end else if (level_d > peak_q) begin
            peak_d = level_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak = peak_q;
`else
    assign peak = '0;
`endif

endmodule

// File: doc/tx_buffer.md
Name: tx_buffer

Overview:
- Byte FIFO between the bf core's tx port (tx_data/tx_send/tx_busy) and the avr_interface tx port (tx_data/new_tx_data/tx_busy).
- Absorbs bursts from the interpreter so bf stalls only when the FIFO is full, not on every serial byte.
- Replaces the direct wire-through of tx_data/tx_send/tx_busy at the top level. Clocked on clk100.

Parameters:
- LOGDEPTH, 4, log2 of FIFO depth; DEPTH = 2**LOGDEPTH entries (16).

Ports:
- clk  input  1  system clock (100 MHz domain).
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of FIFO contents.
- a_data  input  8  byte from producer (bf tx_data).
- a_send  input  1  producer write strobe, one cycle per byte.
- a_busy  output  1  FIFO full; producer must not strobe a_send.
- b_data  output  8  byte to consumer (avr tx_data).
- b_send  output  1  one-cycle send pulse (avr new_tx_data).
- b_busy  input  1  consumer busy (avr tx_busy).
- level  output  LOGDEPTH+1  current occupancy, 0..DEPTH.
- peak  output  LOGDEPTH+1  high-water mark (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values while rst_n=0: wr_ptr=0, rd_ptr=0, level=0, b_data=0, b_send=0, peak=0, state=IDLE. a_busy=0, since it is derived from level.
- a_busy = (level == DEPTH). This is combinational from the registered level and has no dependence on a same-cycle pop.
- Push: a_send && !a_busy writes a_data at wr_ptr. wr_ptr increments modulo DEPTH.
- A push attempted while a_busy=1 is dropped silently. No state changes.
- Output FSM states: IDLE, PULSE, HOLD.
- IDLE: if level != 0 && !b_busy, then:
  - b_data <= mem[rd_ptr]; rd_ptr increments modulo DEPTH;
  - level decrements;
  - go to PULSE.
- PULSE: b_send=1 for exactly this cycle; b_data is valid. Go to HOLD unconditionally.
- HOLD: b_busy is ignored for one cycle, covering the consumer's one-cycle lag in raising tx_busy. Go to IDLE.
- b_send is a registered decode of state==PULSE.
- b_data is held stable from the pop until the next pop.
- Minimum spacing between b_send pulses: 3 cycles.
- Latency: a byte pushed into an empty FIFO with b_busy=0 produces b_send 3 cycles after its a_send cycle:
  - push at cycle t;
  - level visible at t+1, pop at t+1;
  - b_send registered at t+2 and visible at t+3.
- Push and pop in the same cycle: level is unchanged. A push while level==DEPTH is blocked by a_busy even if a pop occurs that cycle.
- The pop decision uses the pre-push level. A byte pushed into an empty FIFO is never popped in its push cycle.
- flush=1:
  - wr_ptr, rd_ptr and level are set to 0; any same-cycle push or pop is discarded.
  - An FSM already in PULSE or HOLD completes normally. The already-latched byte is still sent.
  - b_data is not cleared.
- Reset mid-operation aborts any pulse immediately. No partial b_send.
- Pointers carry no wrap bit. Full/empty come from the level counter only.

Optional Feature:
- Macro: TX_BUFFER_PEAK_EN.
- Defined: peak is a registered high-water mark of level.
  - Updates when the next level exceeds peak.
  - Cleared by reset and by flush.
  - Saturates at DEPTH.
- Undefined: peak is tied to 0; no register is inferred.

Decomposition:
- Shared package tx_buffer_pkg holds:
  - FSM state encodings: IDLE=2'd0, PULSE=2'd1, HOLD=2'd2;
  - the DEPTH derivation from LOGDEPTH;
  - the MIN_SEND_GAP=3 constant used by the bench.
- One sub-module, tx_buffer_mem: DEPTH x 8 storage with a synchronous write port and an asynchronous read port. The read is registered by the parent into b_data, so it can map to distributed RAM.

Test Plan:
- Single byte: reset, b_busy=0, push 8'h41 at cycle 10 -> b_send=1 at cycle 13 with b_data=8'h41; level 1 then 0; a_busy never 1.
- Burst fill: b_busy=1, push 8'h00..8'h0F on consecutive cycles -> level=16, a_busy=1. A 17th push of 8'hFF is dropped. Release b_busy -> bytes 00..0F emerge in order, pulses exactly 3 cycles apart, final level=0.
- Consumer backpressure: b_busy toggles high for 20 cycles after each b_send -> no b_send while b_busy=1 in IDLE; all 5 bytes 8'h61..8'h65 delivered once, in order.
- Simultaneous push/pop at level 5 -> level stays 5. Push at level 16 with a same-cycle pop -> push dropped, level 15.
- Flush during PULSE with level 7 -> current byte still sent, level=0 next cycle, no further b_send. With TX_BUFFER_PEAK_EN, peak=0 after flush.
- Async reset: assert rst_n=0 mid-HOLD with level 9, between clock edges -> b_send=0, level=0, a_busy=0, b_data=0 immediately. Without TX_BUFFER_PEAK_EN, peak reads 0 throughout.
